// File: rtl/parking_meter_ctrl_if.sv
// rtl/parking_meter_ctrl_if.sv - tick, button, switch and status signals of the parking meter controller
interface parking_meter_ctrl_if #(
  parameter int N_BTN  = 4,
  parameter int TIME_W = 16
);
  logic              sec_tick;
  logic              half_tick;
  logic [N_BTN-1:0]  add_btn;
  logic [1:0]        preset_sw;
  logic [TIME_W-1:0] time_left;
  logic [1:0]        mode;
  logic              led;
  logic              expired_pulse;

  modport master (
    output sec_tick, half_tick, add_btn, preset_sw,
    input  time_left, mode, led, expired_pulse
  );

  modport slave (
    input  sec_tick, half_tick, add_btn, preset_sw,
    output time_left, mode, led, expired_pulse
  );
endinterface

// File: rtl/parking_meter_ctrl.sv
// rtl/parking_meter_ctrl.sv - parking meter credit/countdown controller with mode decode and LED blink
// Optional button auto-repeat is built when PARKING_AUTOREPEAT_EN is defined.
module parking_meter_ctrl #(
  parameter int                   TIME_W     = 16,
  parameter int                   N_BTN      = 4,
  parameter logic [N_BTN*16-1:0]  ADD_AMTS   = {16'd500, 16'd200, 16'd150, 16'd50},
  parameter int                   MAX_TIME   = 9999,
  parameter int                   LOW_THRESH = 200,
  parameter int                   PRESET0    = 10,
  parameter int                   PRESET1    = 205,
  parameter int                   REPEAT_DLY = 2
) (
  input logic               clk,
  input logic               rst_n,
  parking_meter_ctrl_if.slave bus
);

  localparam int SUM_W = TIME_W + 4;

  typedef enum logic [1:0] {
    MODE_ACTIVE  = 2'b01,
    MODE_EXPIRED = 2'b10,
    MODE_LOW     = 2'b11
  } mode_e;

  logic [TIME_W-1:0] time_q, time_d, t1;
  mode_e             mode_q, mode_d;
  logic              led_q, led_d;
  logic              pulse_q, pulse_d;
  logic [N_BTN-1:0]  btn_q;
  logic [N_BTN-1:0]  rise;
  logic [N_BTN-1:0]  rpt;
  logic              preset_act;
  logic [SUM_W-1:0]  sum, total;

  assign rise       = bus.add_btn & ~btn_q;
  assign preset_act = |bus.preset_sw;

`ifdef PARKING_AUTOREPEAT_EN
  localparam int HC_W = $clog2(REPEAT_DLY + 1);

  // Per-button count of sec_ticks seen since the rising edge, saturating at REPEAT_DLY.
  logic [HC_W-1:0] hold_q [N_BTN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!bus.add_btn[i] || preset_act || rise[i])
          hold_q[i] <= '0;
        else if (bus.sec_tick && hold_q[i] != HC_W'(REPEAT_DLY))
          hold_q[i] <= hold_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rpt = '0;
    for (int i = 0; i < N_BTN; i++)
      rpt[i] = bus.add_btn[i] && !rise[i] && !preset_act && bus.sec_tick
               && (hold_q[i] == HC_W'(REPEAT_DLY));
  end
`else
  assign rpt = '0;
`endif

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_BTN; i++)
      if (rise[i] || rpt[i])
        sum = sum + SUM_W'(ADD_AMTS[i*16 +: 16]);
  end

  assign total = SUM_W'(time_q) + sum;
  assign t1    = (total > SUM_W'(MAX_TIME)) ? TIME_W'(MAX_TIME) : total[TIME_W-1:0];

  function automatic mode_e decode(input logic [TIME_W-1:0] t);
    if (t == '0)                      return MODE_EXPIRED;
    else if (t <= TIME_W'(LOW_THRESH)) return MODE_LOW;
    else                              return MODE_ACTIVE;
  endfunction

  always_comb begin
    time_d  = t1;
    pulse_d = 1'b0;
    if (bus.preset_sw[1]) begin
      time_d = TIME_W'(PRESET1);
    end else if (bus.preset_sw[0]) begin
      time_d = TIME_W'(PRESET0);
    end else if (bus.sec_tick && t1 != '0) begin
      time_d  = t1 - 1'b1;
      pulse_d = (t1 == TIME_W'(1)) && (time_q != '0);
    end

    mode_d = decode(time_d);

    // A mode change restarts the blink with the LED on.
    led_d = led_q;
    if (mode_d != mode_q) begin
      led_d = 1'b1;
    end else begin
      case (mode_q)
        MODE_ACTIVE:  led_d = 1'b1;
        MODE_LOW:     if (bus.half_tick) led_d = ~led_q;
        MODE_EXPIRED: if (bus.sec_tick)  led_d = ~led_q;
        default:      led_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q  <= '0;
      mode_q  <= MODE_EXPIRED;
      led_q   <= 1'b1;
      pulse_q <= 1'b0;
      btn_q   <= '0;
    end else begin
      time_q  <= time_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      pulse_q <= pulse_d;
      btn_q   <= bus.add_btn;
    end
  end

  assign bus.time_left     = time_q;
  assign bus.mode          = mode_q;
  assign bus.led           = led_q;
  assign bus.expired_pulse = pulse_q;

endmodule

// File: tb/tb_parking_meter_ctrl.sv
// tb/tb_parking_meter_ctrl.sv - self-checking bench for parking_meter_ctrl
module tb_parking_meter_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  parking_meter_ctrl_if #(.N_BTN(4), .TIME_W(16)) bus ();

  parking_meter_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        sec;
    logic        half;
    logic [3:0]  btn;
    logic [1:0]  psw;
    int          t;
    int          m;
    int          l;
    int          p;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input int t, input int m, input int l, input int p);
    chk({name, ".time"},  32'(bus.time_left),     t);
    chk({name, ".mode"},  32'(bus.mode),          m);
    chk({name, ".led"},   32'(bus.led),           l);
    chk({name, ".pulse"}, 32'(bus.expired_pulse), p);
  endtask

  task automatic step(input logic s, input logic h, input logic [3:0] b, input logic [1:0] p);
    @(negedge clk);
    bus.sec_tick  = s;
    bus.half_tick = h;
    bus.add_btn   = b;
    bus.preset_sw = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.sec_tick = 0; bus.half_tick = 0; bus.add_btn = 0; bus.preset_sw = 0;
    rst_n = 1'b0;
    #1;
    chk_out("reset", 0, 2, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_rpt [5];

  initial begin
    //            sec half btn      psw    time mode led pulse
    vecs[0]  = '{1'b0, 1'b0, 4'b0001, 2'b00,  50, 3, 1, 0};
    vecs[1]  = '{1'b0, 1'b0, 4'b0000, 2'b00,  50, 3, 1, 0};
    vecs[2]  = '{1'b0, 1'b0, 4'b1000, 2'b00, 550, 1, 1, 0};
    vecs[3]  = '{1'b0, 1'b0, 4'b0000, 2'b00, 550, 1, 1, 0};
    vecs[4]  = '{1'b0, 1'b0, 4'b0000, 2'b10, 205, 1, 1, 0};
    vecs[5]  = '{1'b1, 1'b1, 4'b0000, 2'b00, 204, 1, 1, 0};
    vecs[6]  = '{1'b1, 1'b1, 4'b0000, 2'b00, 203, 1, 1, 0};
    vecs[7]  = '{1'b1, 1'b1, 4'b0000, 2'b00, 202, 1, 1, 0};
    vecs[8]  = '{1'b1, 1'b1, 4'b0000, 2'b00, 201, 1, 1, 0};
    vecs[9]  = '{1'b1, 1'b1, 4'b0000, 2'b00, 200, 3, 1, 0};
    vecs[10] = '{1'b0, 1'b1, 4'b0000, 2'b00, 200, 3, 0, 0};
    vecs[11] = '{1'b0, 1'b1, 4'b0000, 2'b00, 200, 3, 1, 0};
    vecs[12] = '{1'b0, 1'b0, 4'b0000, 2'b00, 200, 3, 1, 0};
    vecs[13] = '{1'b0, 1'b0, 4'b0000, 2'b01,  10, 3, 1, 0};
    vecs[14] = '{1'b1, 1'b0, 4'b0000, 2'b01,  10, 3, 1, 0};
    vecs[15] = '{1'b1, 1'b1, 4'b0000, 2'b00,   9, 3, 0, 0};

`ifdef PARKING_AUTOREPEAT_EN
    exp_rpt = '{149, 148, 297, 446, 595};
`else
    exp_rpt = '{149, 148, 147, 146, 145};
`endif

    bus.sec_tick = 0; bus.half_tick = 0; bus.add_btn = 0; bus.preset_sw = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("por", 0, 2, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].sec, vecs[i].half, vecs[i].btn, vecs[i].psw);
      chk_out($sformatf("vec%0d", i), vecs[i].t, vecs[i].m, vecs[i].l, vecs[i].p);
    end

    // Countdown from 9 to expiry, then expired-mode blinking.
    for (int i = 8; i >= 1; i--) begin
      step(1, 1, 4'b0000, 2'b00);
      chk($sformatf("cd%0d.time", i), 32'(bus.time_left), i);
      chk($sformatf("cd%0d.pulse", i), 32'(bus.expired_pulse), 0);
    end
    step(1, 1, 4'b0000, 2'b00); chk_out("expire", 0, 2, 1, 1);
    step(0, 0, 4'b0000, 2'b00); chk_out("exp_idle", 0, 2, 1, 0);
    step(1, 1, 4'b0000, 2'b00); chk_out("exp_tick1", 0, 2, 0, 0);
    step(0, 1, 4'b0000, 2'b00); chk_out("exp_half", 0, 2, 0, 0);
    step(1, 1, 4'b0000, 2'b00); chk_out("exp_tick2", 0, 2, 1, 0);
    step(1, 1, 4'b0001, 2'b00); chk_out("add_at_zero", 49, 3, 1, 0);
    step(0, 0, 4'b0000, 2'b00);

    // Asynchronous reset mid-operation.
    do_reset();

    // Build 9900: 19 x 500 + 2 x 200.
    for (int i = 0; i < 19; i++) begin
      step(0, 0, 4'b1000, 2'b00);
      step(0, 0, 4'b0000, 2'b00);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 4'b0100, 2'b00);
      step(0, 0, 4'b0000, 2'b00);
    end
    chk_out("build9900", 9900, 1, 1, 0);
    step(1, 1, 4'b1111, 2'b00); chk_out("sat_tick", 9998, 1, 1, 0);
    step(0, 0, 4'b0000, 2'b00);
    step(0, 0, 4'b1000, 2'b00); chk_out("sat_add", 9999, 1, 1, 0);
    step(0, 0, 4'b0000, 2'b00);

    // Both presets held: PRESET1 wins, adds and ticks ignored, edges consumed.
    step(1, 1, 4'b1111, 2'b11); chk_out("pre_a", 205, 1, 1, 0);
    step(1, 1, 4'b0000, 2'b11); chk_out("pre_b", 205, 1, 1, 0);
    step(0, 1, 4'b0101, 2'b11); chk_out("pre_c", 205, 1, 1, 0);
    step(1, 0, 4'b0101, 2'b11); chk_out("pre_d", 205, 1, 1, 0);
    step(1, 1, 4'b0101, 2'b00); chk_out("pre_rel", 204, 1, 1, 0);
    step(0, 0, 4'b0000, 2'b00);

    // Hold add_btn[1] from zero across five sec_ticks.
    do_reset();
    step(0, 0, 4'b0010, 2'b00); chk_out("hold_edge", 150, 3, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 4'b0010, 2'b00);
      chk($sformatf("hold%0d.time", i), 32'(bus.time_left), exp_rpt[i]);
    end
    step(0, 0, 4'b0000, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
